// File: rtl/music_player.sv
// rtl/music_player.sv - score-driven square-wave music player
//
// Steps through SCORE_LEN entries of an external synchronous-read score RAM,
// one entry per BEAT_CYCLES clocks, and plays each entry as a square wave.
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   start, stop                 one-cycle control pulses (stop wins)
//   pause, loop_en              level controls
//   ram_re, ram_addr, ram_data  score read port, data valid the cycle after ram_re
//   buzzer                      tone output
//   octave, note_digit          decoded current note (0/0 for a rest)
//   playing, done               busy status; end-of-score pulse
module music_player #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int SCORE_LEN   = 135,
   parameter int ADDR_WIDTH  = 8,
   parameter int RAM_WIDTH   = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   input  logic                  loop_en,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [RAM_WIDTH-1:0]  ram_data,
   output logic                  buzzer,
   output logic [1:0]            octave,
   output logic [3:0]            note_digit,
   output logic                  playing,
   output logic                  done
);

   localparam int BW = $clog2(BEAT_CYCLES);
   localparam int TW = 18;
   localparam logic [BW-1:0]         BEAT_LAST = BW'(BEAT_CYCLES - 3);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SCORE_LEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_PAUSE} state_t;

   state_t        state, state_next;
   logic [BW-1:0] beat_cnt;
   logic [TW-1:0] tone_cnt;
   logic          tone_q;
   logic          end_q;

   logic [3:0]    sel_field;
   logic [1:0]    dec_octave;
   logic [3:0]    dec_digit;
   logic [TW-1:0] base;
   logic [TW-1:0] half_period;
   logic [TW-1:0] tone_cnt_step;
   logic          tone_q_step;
   logic          beat_end;
   logic          at_last;
   logic          finish;

   // Score word {high, med, low, cs}: a one-hot cs picks the field and the
   // octave; anything that is not a digit 1-7 plays as a rest.
   always_comb begin
      sel_field  = 4'd0;
      dec_octave = 2'd0;
      dec_digit  = 4'd0;
      case (ram_data[2:0])
         3'b001: begin sel_field = ram_data[6:3];   dec_octave = 2'd1; end
         3'b010: begin sel_field = ram_data[10:7];  dec_octave = 2'd2; end
         3'b100: begin sel_field = ram_data[14:11]; dec_octave = 2'd3; end
         default: ;
      endcase
      if (sel_field == 4'd0 || sel_field > 4'd7)
         dec_octave = 2'd0;
      else
         dec_digit = sel_field;
   end

   always_comb begin
      case (note_digit)
         4'd1:    base = 18'd190840;
         4'd2:    base = 18'd170068;
         4'd3:    base = 18'd151515;
         4'd4:    base = 18'd143266;
         4'd5:    base = 18'd127551;
         4'd6:    base = 18'd113636;
         4'd7:    base = 18'd101215;
         default: base = '0;
      endcase
   end

   always_comb begin
      case (octave)
         2'd2:    half_period = base >> 1;
         2'd3:    half_period = base >> 2;
         default: half_period = base;
      endcase
   end

   // One tone-generator step; a rest forces the wave low and the phase to zero.
   always_comb begin
      tone_cnt_step = tone_cnt + 1'b1;
      tone_q_step   = tone_q;
      if (octave == 2'd0) begin
         tone_cnt_step = '0;
         tone_q_step   = 1'b0;
      end else if (tone_cnt == half_period - 1'b1) begin
         tone_cnt_step = '0;
         tone_q_step   = ~tone_q;
      end
   end

   assign beat_end = (state == S_PLAY) && (beat_cnt == BEAT_LAST);
   assign at_last  = (ram_addr >= ADDR_LAST);
   assign finish   = beat_end && at_last && !loop_en && !stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // End of beat takes precedence over pause, so a pause that lands on the
   // last PLAY cycle is picked up in the next entry's PLAY.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start && !stop) state_next = S_FETCH;
         S_FETCH: state_next = stop ? S_IDLE : S_LOAD;
         S_LOAD:  state_next = stop ? S_IDLE : S_PLAY;
         S_PLAY: begin
            if (stop)
               state_next = S_IDLE;
            else if (beat_end)
               state_next = (at_last && !loop_en) ? S_IDLE : S_FETCH;
            else if (pause)
               state_next = S_PAUSE;
         end
         S_PAUSE: begin
            if (stop)
               state_next = S_IDLE;
            else if (!pause)
               state_next = S_PLAY;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // The tone phase is kept through PAUSE; only the pin is gated.
   always_comb begin
      ram_re  = (state == S_FETCH);
      playing = (state != S_IDLE);
      buzzer  = tone_q && (state != S_PAUSE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr   <= '0;
         octave     <= 2'd0;
         note_digit <= 4'd0;
         beat_cnt   <= '0;
         tone_cnt   <= '0;
         tone_q     <= 1'b0;
         end_q      <= 1'b0;
         done       <= 1'b0;
      end else begin
         // done is delayed one extra cycle so it lands on the beat boundary
         // where the next LOAD would otherwise have happened.
         end_q <= finish;
         done  <= end_q;
         if (state != S_IDLE && stop) begin
            ram_addr   <= '0;
            octave     <= 2'd0;
            note_digit <= 4'd0;
            beat_cnt   <= '0;
            tone_cnt   <= '0;
            tone_q     <= 1'b0;
         end else begin
            case (state)
               S_FETCH: begin
                  tone_cnt <= tone_cnt_step;
                  tone_q   <= tone_q_step;
               end
               S_LOAD: begin
                  octave     <= dec_octave;
                  note_digit <= dec_digit;
                  beat_cnt   <= '0;
                  // A repeated note keeps its phase so tied notes do not click.
                  if ({dec_octave, dec_digit} != {octave, note_digit}) begin
                     tone_cnt <= '0;
                     tone_q   <= 1'b0;
                  end else begin
                     tone_cnt <= tone_cnt_step;
                     tone_q   <= tone_q_step;
                  end
               end
               S_PLAY: begin
                  beat_cnt <= beat_cnt + 1'b1;
                  tone_cnt <= tone_cnt_step;
                  tone_q   <= tone_q_step;
                  if (beat_end) begin
                     if (!at_last) begin
                        ram_addr <= ram_addr + 1'b1;
                     end else begin
                        ram_addr <= '0;
                        if (!loop_en) begin
                           octave     <= 2'd0;
                           note_digit <= 4'd0;
                           tone_cnt   <= '0;
                           tone_q     <= 1'b0;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_music_player.sv
// tb/tb_music_player.sv - directed self-checking bench for music_player
module tb_music_player;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic        pause;
   logic        loop_en;
   logic        ram_re;
   logic [7:0]  ram_addr;
   logic [14:0] ram_data;
   logic        buzzer;
   logic [1:0]  octave;
   logic [3:0]  note_digit;
   logic        playing;
   logic        done;

   music_player #(
      .BEAT_CYCLES(8),
      .SCORE_LEN  (4),
      .ADDR_WIDTH (8),
      .RAM_WIDTH  (15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .loop_en   (loop_en),
      .ram_re    (ram_re),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .buzzer    (buzzer),
      .octave    (octave),
      .note_digit(note_digit),
      .playing   (playing),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [14:0] mem [0:3];
   always @(posedge clk) ram_data <= ram_re ? mem[ram_addr[1:0]] : 15'd0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [63:0] re_h;
   logic [63:0] done_h;
   logic [1:0]  oct_h  [0:63];
   logic [3:0]  dig_h  [0:63];
   logic [7:0]  addr_h [0:63];
   logic        play_h [0:63];
   logic        buz_h  [0:63];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   // Cycle 0 carries the start pulse; history index c is sampled during cycle c.
   task automatic run_score(input int n, input logic lp, input int p_lo, input int p_hi,
                            input int ss_cyc);
      re_h    = '0;
      done_h  = '0;
      loop_en = lp;
      for (int c = 0; c < n; c++) begin
         if (c > 0) tick();
         re_h[c]   = ram_re;
         done_h[c] = done;
         oct_h[c]  = octave;
         dig_h[c]  = note_digit;
         addr_h[c] = ram_addr;
         play_h[c] = playing;
         buz_h[c]  = buzzer;
         start = (c == 0) || (c == ss_cyc);
         stop  = (c == ss_cyc);
         pause = (c >= p_lo) && (c <= p_hi);
      end
      tick();
      start = 1'b0;
      stop  = 1'b0;
      pause = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      pause   = 1'b0;
      loop_en = 1'b0;
      mem[0] = {4'd0, 4'd0, 4'd3, 3'b001};
      mem[1] = {4'd0, 4'd0, 4'd0, 3'b010};
      mem[2] = {4'd0, 4'd5, 4'd5, 3'b011};
      mem[3] = {4'd6, 4'd2, 4'd0, 3'b010};
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {ram_re, ram_addr, buzzer, octave, note_digit, playing, done}, 64'd0);
      rst = 1'b0;
      tick();
      tick();

      // Full score, no loop
      run_score(40, 1'b0, -1, -1, -1);
      check("noloop_fetch_cycles", re_h, 64'h0000_0000_0202_0202);
      check("noloop_done_cycles", done_h, 64'h0000_0004_0000_0000);
      check("noloop_fetch_addrs", {addr_h[25], addr_h[17], addr_h[9], addr_h[1]}, {8'd3, 8'd2, 8'd1, 8'd0});
      check("decode_low3", {oct_h[3], dig_h[3], play_h[3]}, {2'd1, 4'd3, 1'b1});
      check("decode_rest_zero", {oct_h[11], dig_h[11], buz_h[11]}, 64'd0);
      check("decode_rest_cs011", {oct_h[19], dig_h[19]}, 64'd0);
      check("decode_med2", {oct_h[27], dig_h[27]}, {2'd2, 4'd2});
      check("noloop_end_state", {play_h[35], addr_h[35], oct_h[35], dig_h[35], buz_h[35]}, 64'd0);

      // Looping, then stop+start together during PLAY
      run_score(40, 1'b1, -1, -1, 36);
      check("loop_fetch_cycles", re_h, 64'h0000_0002_0202_0202);
      check("loop_wrap_addr", addr_h[33], 64'd0);
      check("loop_wrap_decode", {oct_h[35], dig_h[35]}, {2'd1, 4'd3});
      check("loop_no_done", done_h, 64'd0);
      check("stop_start_idle", {play_h[37], play_h[38], addr_h[37], oct_h[37], buz_h[37]}, 64'd0);

      // Pause for 20 cycles during entry 1
      run_score(60, 1'b0, 12, 31, -1);
      check("pause_fetch_cycles", re_h, 64'h0000_2020_0000_0202);
      check("pause_done_cycle", done_h, 64'h0040_0000_0000_0000);
      check("pause_status", {play_h[20], buz_h[20]}, 2'b10);

      // Asynchronous reset mid-beat
      loop_en = 1'b0;
      cyc     = 0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      run_to(5);
      check("rst_pre_note", {octave, note_digit, playing}, {2'd1, 4'd3, 1'b1});
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_outputs", {ram_re, ram_addr, buzzer, octave, note_digit, playing, done}, 64'd0);
      #1;
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("rst_waits_start", {playing, ram_re, ram_addr}, 64'd0);

      // Tied high-7 notes: half period 101215>>2 = 25303 cycles
      for (int i = 0; i < 4; i++) mem[i] = {4'd7, 4'd0, 4'd0, 3'b100};
      loop_en = 1'b1;
      cyc     = 0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      run_to(25305);
      check("tie_before_rise", buzzer, 64'd0);
      tick();
      check("tie_rise", buzzer, 64'd1);
      run_to(25308);
      pause = 1'b1;
      run_to(25310);
      check("tie_pause_gated", {buzzer, playing}, 2'b01);
      run_to(25313);
      pause = 1'b0;
      run_to(25315);
      check("tie_pause_resume", buzzer, 64'd1);
      run_to(50613);
      check("tie_before_fall", {buzzer, octave, note_digit}, {1'b1, 2'd3, 4'd7});
      tick();
      check("tie_fall", buzzer, 64'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("tie_stop_clears", {playing, octave, note_digit, buzzer, ram_addr, done}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- BEAT_CYCLES, 12_500_000, clk cycles per beat; minimum 4.
- SCORE_LEN, 135, number of score entries.
- ADDR_WIDTH, 8, score address width.
- RAM_WIDTH, 15, score word width: {high[3:0], med[3:0], low[3:0], cs[2:0]}.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, system clock, 100 MHz.
- rst, in, 1, reset.
- start, in, 1, one-cycle pulse; begins playback at address 0.
- stop, in, 1, one-cycle pulse; aborts playback.
- pause, in, 1, level; freezes playback while high.
- loop_en, in, 1, level; repeat the score after the last entry.
- ram_re, out, 1, score read enable.
- ram_addr, out, ADDR_WIDTH, score read address.
- ram_data, in, RAM_WIDTH, score word; valid the cycle after ram_re.
- buzzer, out, 1, square-wave tone output.
- octave, out, 2, current note octave: 0 rest, 1 low, 2 med, 3 high.
- note_digit, out, 4, current note digit 1-7; 0 for rest.
- playing, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at the natural end of the score.
REQ-003 Clock and reset are fixed: single clock clk; rst is asynchronous and active-high.

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, LOAD, PLAY and PAUSE.
REQ-005 IDLE + start SHALL go to FETCH with ram_addr=0.
REQ-006 FETCH SHALL last 1 cycle with ram_re=1; ram_re SHALL be 0 in every other state.
REQ-007 LOAD SHALL last 1 cycle: capture ram_data, decode per REQ-011, clear the beat counter, go to PLAY.
REQ-008 PLAY SHALL last BEAT_CYCLES-2 cycles, so LOAD-to-LOAD spacing is exactly BEAT_CYCLES. At the end of PLAY:
- if ram_addr < SCORE_LEN-1: ram_addr+1, go to FETCH;
- else if loop_en: ram_addr=0, go to FETCH;
- else: go to IDLE, ram_addr=0, done=1 for one cycle, octave, note_digit and buzzer cleared.
REQ-009 pause=1 in PLAY SHALL enter PAUSE the next cycle. In PAUSE the beat counter and tone counter hold and buzzer=0. pause=0 SHALL return to PLAY and resume the remaining beat count. pause in FETCH or LOAD takes effect only once in PLAY.
REQ-010 Control priority:
- stop in any non-IDLE state SHALL go to IDLE next cycle, ram_addr=0, buzzer/octave/note_digit=0, no done pulse.
- stop and start in the same cycle: stop wins.
- start outside IDLE SHALL be ignored.
REQ-011 Decode of the captured word:
- cs=001 selects low (octave 1); cs=010 selects med (octave 2); cs=100 selects high (octave 3).
- The selected field 1-7 becomes note_digit.
- Selected field 0 or 8-15, or cs not one-hot, SHALL decode as rest: octave=0, note_digit=0.
REQ-012 Tone base half-periods for octave 1, digits 1-7, in cycles: 190840, 170068, 151515, 143266, 127551, 113636, 101215.
REQ-013 half_period = base >> (octave-1). buzzer SHALL toggle each time a counter reaches half_period-1, and the counter then restarts at 0.
REQ-014 Tone phase:
- In LOAD with an unchanged {octave, note_digit}, the tone counter and buzzer SHALL continue uninterrupted (tied notes, no click).
- On a change, the counter SHALL clear and buzzer SHALL go to 0.
- Rest SHALL hold buzzer=0.
REQ-015 The beat counter SHALL be wide enough for BEAT_CYCLES-1 and SHALL never wrap within a beat.

Reset
REQ-016 rst=1 SHALL immediately force state=IDLE and all outputs to 0: ram_re, ram_addr, buzzer, octave, note_digit, playing, done.
REQ-017 rst mid-playback SHALL discard the note and address; after release the block waits for start.

Verification
Bench: BEAT_CYCLES=8, SCORE_LEN=4, synchronous-read RAM model that returns 0 when re=0.
REQ-018 Start: start at cycle 0 -> ram_re=1, ram_addr=0 at cycle 1; LOAD at cycle 2; word {0,0,3,001} -> octave=1, note_digit=3, playing=1; buzzer toggles every 151515 cycles.
REQ-019 End without loop: loop_en=0 -> LOADs at cycles 2, 10, 18, 26; done=1 at cycle 34 only; then playing=0, ram_addr=0.
REQ-020 Loop: loop_en=1 -> after address 3, FETCH with ram_addr=0; done stays 0.
REQ-021 Pause: pause high for 20 cycles during PLAY of entry 1 -> buzzer=0 during the pause; the next LOAD is 20 cycles late.
REQ-022 Rests and ties:
- {0,0,0,010} -> octave=0, buzzer=0.
- cs=011 -> rest.
- Two identical consecutive entries -> buzzer toggle spacing uninterrupted across LOAD.
REQ-023 Stop and reset:
- stop and start in the same cycle during PLAY -> IDLE, no done.
- rst asserted mid-beat -> all outputs 0 in the same cycle, asynchronously.
